// File: rtl/vita49_unpack.sv
// ---------------------------------------------------------------------------
// vita49_unpack
//   Receive-side VITA-49 IF-data unpacker. Accepts packets on an AXIS slave
//   port (hdr, stream ID, integer TS, two fractional TS words, payload),
//   validates the header, captures timestamps and forwards only payload words
//   to the AXIS master port with zero latency.
//
// Ports
//   AXIS_ACLK / AXIS_ARESET   clock, synchronous active-high reset
//   S_AXIS_*                  packet input (TDATA/TVALID/TLAST/TREADY)
//   M_AXIS_*                  payload output (TDATA/TVALID/TLAST/TREADY)
//   ctrl                      [0] start, [1] reset_cmd, [2] passthrough
//   status                    [0] done, [1] hdr_err, [2] sid_err,
//                             [3] seq_err, [4] size_err, [11:8] last pkt_cnt
//   streamID                  expected stream ID
//   words_to_unpack           payload words to forward before done
//   timestamp_sec/_fsec       captured TSI / {TSF0,TSF1}
//   ts_valid                  1-cycle pulse after TSF1 capture
//
// Build option
//   VITA49_UNPACK_SIDFILT_EN  when defined, a stream-ID mismatch drops the
//                             whole packet (DRAIN) instead of forwarding it.
// ---------------------------------------------------------------------------
module vita49_unpack #(
  parameter logic [3:0] PKT_TYPE = 4'b0001
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] ctrl,
  output logic [31:0] status,
  input  logic [31:0] streamID,
  input  logic [31:0] words_to_unpack,
  output logic [31:0] timestamp_sec,
  output logic [63:0] timestamp_fsec,
  output logic        ts_valid
);

  localparam logic [15:0] HDR_WORDS = 16'd5;

  localparam logic [3:0] ST_INIT  = 4'd0;
  localparam logic [3:0] ST_HDR   = 4'd1;
  localparam logic [3:0] ST_SID   = 4'd2;
  localparam logic [3:0] ST_TSI   = 4'd3;
  localparam logic [3:0] ST_TSF0  = 4'd4;
  localparam logic [3:0] ST_TSF1  = 4'd5;
  localparam logic [3:0] ST_PAY   = 4'd6;
  localparam logic [3:0] ST_DRAIN = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  logic        start, reset_cmd, pass;
  logic [3:0]  state;
  logic [15:0] pkt_size, pay_cnt;
  logic [31:0] word_cnt;
  logic [3:0]  last_cnt, exp_cnt;
  logic        seen_pkt;
  logic        done, hdr_err, sid_err, seq_err, size_err;
  logic        s_xfr, m_xfr;
  logic        hdr_bad, pay_last, budget_hit;

  assign start     = ctrl[0];
  assign reset_cmd = ctrl[1];
  assign pass      = ctrl[2];

  assign hdr_bad    = (S_AXIS_TDATA[31:28] != PKT_TYPE) ||
                      (S_AXIS_TDATA[15:0] <= HDR_WORDS) || S_AXIS_TLAST;
  // pkt_size > 5 is guaranteed whenever PAYLOAD is reached
  assign pay_last   = ((pay_cnt + 16'd1) == (pkt_size - HDR_WORDS));
  assign budget_hit = ((word_cnt + 32'd1) == words_to_unpack);

  assign status = {20'd0, last_cnt, 3'd0, size_err, seq_err, sid_err, hdr_err, done};

  // Output muxing. reset_cmd blocks handshakes so an abandoned packet does
  // not leak one more word downstream.
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = 32'd0;
    if (AXIS_ARESET) begin
      S_AXIS_TREADY = 1'b0;
    end else if (pass) begin
      M_AXIS_TVALID = S_AXIS_TVALID;
      M_AXIS_TLAST  = S_AXIS_TLAST;
      M_AXIS_TDATA  = S_AXIS_TDATA;
      S_AXIS_TREADY = M_AXIS_TREADY;
    end else if (!reset_cmd) begin
      case (state)
        ST_HDR, ST_SID, ST_TSI, ST_TSF0, ST_TSF1, ST_DRAIN: S_AXIS_TREADY = 1'b1;
        ST_PAY: begin
          M_AXIS_TVALID = S_AXIS_TVALID;
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TLAST  = S_AXIS_TLAST | pay_last | budget_hit;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end
        default: S_AXIS_TREADY = 1'b0;
      endcase
    end
  end

  assign s_xfr = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_xfr = M_AXIS_TVALID & M_AXIS_TREADY;

  always_ff @(posedge AXIS_ACLK) begin
    ts_valid <= 1'b0;
    if (AXIS_ARESET) begin
      state          <= ST_INIT;
      pkt_size       <= 16'd0;
      pay_cnt        <= 16'd0;
      word_cnt       <= 32'd0;
      last_cnt       <= 4'd0;
      exp_cnt        <= 4'd0;
      seen_pkt       <= 1'b0;
      done           <= 1'b0;
      hdr_err        <= 1'b0;
      sid_err        <= 1'b0;
      seq_err        <= 1'b0;
      size_err       <= 1'b0;
      timestamp_sec  <= 32'd0;
      timestamp_fsec <= 64'd0;
    end else if (reset_cmd || (!pass && state == ST_INIT)) begin
      // status and counters clear on the way into INIT and while in it
      word_cnt <= 32'd0;
      last_cnt <= 4'd0;
      exp_cnt  <= 4'd0;
      seen_pkt <= 1'b0;
      done     <= 1'b0;
      hdr_err  <= 1'b0;
      sid_err  <= 1'b0;
      seq_err  <= 1'b0;
      size_err <= 1'b0;
      state    <= (!reset_cmd && start) ? ST_HDR : ST_INIT;
    end else if (!pass) begin
      case (state)
        ST_HDR: if (s_xfr) begin
          pkt_size <= S_AXIS_TDATA[15:0];
          last_cnt <= S_AXIS_TDATA[19:16];
          pay_cnt  <= 16'd0;
          if (hdr_bad) begin
            hdr_err <= 1'b1;
          end else begin
            // expected count follows the received one (mod 16) after each
            // good header, so a gap is flagged once and then resyncs
            if (seen_pkt && S_AXIS_TDATA[19:16] != exp_cnt) seq_err <= 1'b1;
            seen_pkt <= 1'b1;
            exp_cnt  <= S_AXIS_TDATA[19:16] + 4'd1;
          end
          if (words_to_unpack == 32'd0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (hdr_bad) begin
            state <= S_AXIS_TLAST ? ST_HDR : ST_DRAIN;
          end else begin
            state <= ST_SID;
          end
        end
        ST_SID: if (s_xfr) begin
          if (S_AXIS_TDATA != streamID) sid_err <= 1'b1;
          if (S_AXIS_TLAST) begin
            size_err <= 1'b1;
            state    <= ST_HDR;
          end else begin
`ifdef VITA49_UNPACK_SIDFILT_EN
            state <= (S_AXIS_TDATA != streamID) ? ST_DRAIN : ST_TSI;
`else
            state <= ST_TSI;
`endif
          end
        end
        ST_TSI: if (s_xfr) begin
          timestamp_sec <= S_AXIS_TDATA;
          if (S_AXIS_TLAST) begin size_err <= 1'b1; state <= ST_HDR; end
          else state <= ST_TSF0;
        end
        ST_TSF0: if (s_xfr) begin
          timestamp_fsec[63:32] <= S_AXIS_TDATA;
          if (S_AXIS_TLAST) begin size_err <= 1'b1; state <= ST_HDR; end
          else state <= ST_TSF1;
        end
        ST_TSF1: if (s_xfr) begin
          timestamp_fsec[31:0] <= S_AXIS_TDATA;
          if (S_AXIS_TLAST) begin
            size_err <= 1'b1;
            state    <= ST_HDR;
          end else begin
            ts_valid <= 1'b1;
            state    <= ST_PAY;
          end
        end
        ST_PAY: if (m_xfr) begin
          word_cnt <= word_cnt + 32'd1;
          pay_cnt  <= pay_cnt + 16'd1;
          // word budget wins over any packet-end condition on the same word
          if (budget_hit) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (S_AXIS_TLAST) begin
            if (!pay_last) size_err <= 1'b1;
            state <= ST_HDR;
          end else if (pay_last) begin
            size_err <= 1'b1;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (s_xfr && S_AXIS_TLAST) state <= ST_HDR;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_vita49_unpack.sv
module tb_vita49_unpack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [31:0] ctrl = 32'd1;
  logic [31:0] status;
  logic [31:0] sid_cfg = 32'h0000_BEEF;
  logic [31:0] wtu = 32'd1000;
  logic [31:0] ts_sec;
  logic [63:0] ts_fsec;
  logic        ts_valid;

  vita49_unpack dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
    .ctrl(ctrl), .status(status), .streamID(sid_cfg), .words_to_unpack(wtu),
    .timestamp_sec(ts_sec), .timestamp_fsec(ts_fsec), .ts_valid(ts_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [32:0] stim_q[$];   // {last, data}
  logic [32:0] exp_q[$];    // {last, data}
  logic [95:0] ts_q[$];     // {tsi, tsf0, tsf1}
  bit          toggle = 0;
  bit          chk_en = 0;

  // behavioural model state, per the packet-level rules
  bit        md_done, md_hdr, md_sid, md_seq, md_size, md_seen;
  logic [3:0] md_exp, md_cnt;
  int        md_words;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {20'd0, md_cnt, 3'd0, md_size, md_seq, md_sid, md_hdr, md_done};
  endfunction

  task automatic model_clear();
    md_done = 0; md_hdr = 0; md_sid = 0; md_seq = 0; md_size = 0; md_seen = 0;
    md_exp = 0; md_cnt = 0; md_words = 0;
  endtask

  // Queue a packet of nwords total words (TLAST on the last one) and derive
  // the payload words, timestamps and flags it must produce.
  task automatic add_pkt(input logic [3:0] typ, input logic [3:0] cnt, input int size,
                         input logic [31:0] sid, input int nwords, input logic [15:0] tag);
    logic [31:0] w;
    logic [95:0] ts;
    bit bad;
    int plen, avail, nfwd;
    ts = {32'h5EC0_0000 | {16'd0, tag}, 32'hF000_0000 | {16'd0, tag}, 32'h0000_F000 | {16'd0, tag}};
    for (int i = 0; i < nwords; i++) begin
      case (i)
        0: w = {typ, 4'h0, 2'b01, 2'b01, cnt, size[15:0]};
        1: w = sid;
        2: w = ts[95:64];
        3: w = ts[63:32];
        4: w = ts[31:0];
        default: w = {tag, 16'(i - 5)};
      endcase
      stim_q.push_back({(i == nwords - 1), w});
    end
    if (md_done) return;
    md_cnt = cnt;
    bad = (typ != 4'h1) || (size <= 5) || (nwords == 1);
    if (bad) md_hdr = 1;
    if (wtu == 0) begin md_done = 1; return; end
    if (bad) return;
    if (md_seen && cnt != md_exp) md_seq = 1;
    md_seen = 1;
    md_exp = cnt + 4'd1;
    if (sid != sid_cfg) begin
      md_sid = 1;
`ifdef VITA49_UNPACK_SIDFILT_EN
      if (nwords > 2) return;
`endif
    end
    if (nwords <= 5) begin md_size = 1; return; end
    ts_q.push_back(ts);
    plen  = size - 5;
    avail = nwords - 5;
    nfwd  = (plen < avail) ? plen : avail;
    for (int k = 0; k < nfwd; k++) begin
      md_words++;
      exp_q.push_back({(k == nfwd - 1) || (md_words == int'(wtu)), tag, 16'(k)});
      if (md_words == int'(wtu)) begin md_done = 1; return; end
    end
    if (plen != avail) md_size = 1;
  endtask

  // Drive up to n words from stim_q, one per accepted handshake.
  task automatic run_stim(input int n);
    int sent = 0, to;
    logic [32:0] w;
    while (stim_q.size() > 0 && sent < n) begin
      w = stim_q.pop_front();
      s_valid = 1; s_last = w[32]; s_data = w[31:0];
      to = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        if (++to > 200) break;
      end
      if (to > 200) begin
        chk("stim_timeout", 64'(sent), 64'(sent + 1 + stim_q.size()));
        stim_q.delete();
        break;
      end
      @(posedge clk); #1;
      sent++;
    end
    s_valid = 0; s_last = 0; s_data = 0;
  endtask

  task automatic do_reset();
    rst = 1; ctrl = 32'd1;
    stim_q.delete(); exp_q.delete(); ts_q.delete();
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic end_test(input string name, input logic [31:0] lit_status);
    repeat (4) @(negedge clk);
    chk({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_ts_left"}, 64'(ts_q.size()), 64'd0);
    chk({name, "_status_model"}, 64'(status), 64'(model_status()));
    chk({name, "_status_lit"}, 64'(status), 64'(lit_status));
  endtask

  // M_AXIS_TREADY: always ready, or a coin flip per cycle
  always @(posedge clk) begin
    #1 m_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every output transfer and every ts_valid pulse.
  logic [32:0] e_word;
  logic [95:0] e_ts;
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("out_extra", {31'd0, m_last, m_data}, 64'd0);
        else begin
          e_word = exp_q.pop_front();
          chk("out_word", {31'd0, m_last, m_data}, {31'd0, e_word});
        end
      end
      if (m_valid && !ctrl[2]) chk("s_ready_mirror", {63'd0, s_ready}, {63'd0, m_ready});
      if (ts_valid) begin
        if (ts_q.size() == 0) chk("ts_extra", {32'd0, ts_sec}, 64'd0);
        else begin
          e_ts = ts_q.pop_front();
          chk("ts_sec", {32'd0, ts_sec}, {32'd0, e_ts[95:64]});
          chk("ts_fsec", ts_fsec, e_ts[63:0]);
        end
      end
    end
  end

  initial begin
    // reset state
    do_reset();
    rst = 1;
    @(negedge clk);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_outs", {60'd0, m_valid, m_last, s_ready, ts_valid}, 64'd0);
    chk("rst_ts", {32'd0, ts_sec} | ts_fsec, 64'd0);
    chk_en = 1;

    // T1: two clean packets, 10-word budget
    do_reset(); wtu = 10;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 10, 16'd1);
    add_pkt(4'h1, 4'd1, 10, 32'hBEEF, 10, 16'd2);
    chk("t1_model_w0", 64'(exp_q[0]), 64'h0_0001_0000);
    chk("t1_model_last5", 64'(exp_q[4][32]), 64'd1);
    run_stim(1000);
    end_test("t1", 32'h0000_0101);

    // T2: same with throttled M_AXIS_TREADY
    do_reset(); wtu = 10; toggle = 1;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 10, 16'd1);
    add_pkt(4'h1, 4'd1, 10, 32'hBEEF, 10, 16'd2);
    run_stim(1000);
    end_test("t2", 32'h0000_0101);
    toggle = 0;

    // T3: sequence gap 0 -> 2
    do_reset(); wtu = 1000;
    add_pkt(4'h1, 4'd0, 8, 32'hBEEF, 8, 16'd3);
    add_pkt(4'h1, 4'd2, 8, 32'hBEEF, 8, 16'd4);
    chk("t3_model_n", 64'(exp_q.size()), 64'd6);
    run_stim(1000);
    end_test("t3", 32'h0000_0208);

    // T4: bad type dropped, good packet forwarded
    do_reset(); wtu = 1000;
    add_pkt(4'h4, 4'd0, 10, 32'hBEEF, 10, 16'd5);
    add_pkt(4'h1, 4'd1, 10, 32'hBEEF, 10, 16'd6);
    chk("t4_model_n", 64'(exp_q.size()), 64'd5);
    run_stim(1000);
    end_test("t4", 32'h0000_0102);

    // T5: stream ID mismatch
    do_reset(); wtu = 1000;
    add_pkt(4'h1, 4'd0, 9, 32'hDEAD, 9, 16'd7);
`ifdef VITA49_UNPACK_SIDFILT_EN
    chk("t5_model_n", 64'(exp_q.size()), 64'd0);
`else
    chk("t5_model_n", 64'(exp_q.size()), 64'd4);
`endif
    run_stim(1000);
    end_test("t5", 32'h0000_0004);

    // T6: reset_cmd on 3rd payload word, then a clean packet
    do_reset(); wtu = 1000;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 10, 16'd8);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    run_stim(7);
    s_valid = 1; s_data = 32'h0008_0002; ctrl = 32'd3;
    @(negedge clk);
    chk("t6_idle", {62'd0, m_valid, s_ready}, 64'd0);
    @(posedge clk); #1 ctrl = 32'd1; s_valid = 0;
    stim_q.delete();
    @(negedge clk);
    chk("t6_status_init", 64'(status), 64'd0);
    model_clear();
    add_pkt(4'h1, 4'd3, 10, 32'hBEEF, 10, 16'd9);
    run_stim(1000);
    end_test("t6", 32'h0000_0300);
    chk("t6_tsi_lit", 64'(ts_sec), 64'h5EC0_0009);

    // T7: short packet, long packet, then clean recovery
    do_reset(); wtu = 1000;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 8, 16'd10);
    add_pkt(4'h1, 4'd1, 7, 32'hBEEF, 10, 16'd11);
    add_pkt(4'h1, 4'd2, 7, 32'hBEEF, 7, 16'd12);
    chk("t7_model_n", 64'(exp_q.size()), 64'd7);
    run_stim(1000);
    end_test("t7", 32'h0000_0210);

    // T8: zero budget -> done on first header (which also carries TLAST)
    do_reset(); wtu = 0;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 1, 16'd13);
    run_stim(1000);
    end_test("t8", 32'h0000_0003);

    // T9: budget reached on a word that also carries early TLAST
    do_reset(); wtu = 3;
    add_pkt(4'h1, 4'd0, 10, 32'hBEEF, 8, 16'd14);
    run_stim(1000);
    end_test("t9", 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
